exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0001_0000, PC value driven on redirect while reset is high.
REQ-002 SHALL have parameter VECTOR_ADDR, 32'h0000_0080, exception handler entry address.
REQ-003 SHALL have parameter FLUSH_CYCLES, 2, pipeline flush length in cycles; legal range 1..3.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port overflow  input  1  ALU overflow in EX, one-cycle pulse.
REQ-007 SHALL have port trap  input  1  trap instruction in EX, one-cycle pulse.
REQ-008 SHALL have port memwrite  input  1  store in EX.
REQ-009 SHALL have port oint_ex  input  1  store targets interrupt-output window.
REQ-010 SHALL have port irq_ext  input  1  external interrupt, level-sensitive.
REQ-011 SHALL have port eret  input  1  return-from-exception in EX, one-cycle pulse.
REQ-012 SHALL have port pc_8_in  input  32  PC+8 of the instruction in EX.
REQ-013 SHALL have port flush  output  1  kill IF/ID/EX contents.
REQ-014 SHALL have port pc_sel  output  1  fetch PC = pc_redirect this cycle.
REQ-015 SHALL have port pc_redirect  output  32  redirect target.
REQ-016 SHALL have port epc  output  32  saved return address.
REQ-017 SHALL have port cause  output  3  0 none, 1 overflow, 2 trap, 3 store-int, 4 irq_ext.
REQ-018 SHALL have port int_en  output  1  external-interrupt enable status.
REQ-019 SHALL have port in_handler  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, FLUSH, VECTOR, HANDLER, RETURN; all transitions on rising clk.
REQ-021 SHALL form store_int = memwrite & oint_ex and accept events only in IDLE.
REQ-022 SHALL resolve simultaneous events by priority overflow > trap > store_int > (irq_ext & int_en); only the winner is recorded.
REQ-023 SHALL, on acceptance in IDLE, load cause with the winner code, clear int_en, load flush counter with FLUSH_CYCLES, and go to FLUSH next cycle.
REQ-024 SHALL set epc = pc_8_in - 4 for trap and store_int (resume after), and epc = pc_8_in - 8 for overflow and irq_ext (re-execute); arithmetic modulo 2^32, no saturation.
REQ-025 SHALL assert flush in exactly FLUSH_CYCLES consecutive cycles (the FLUSH state), decrementing a 2-bit counter, leaving at count 1.
REQ-026 SHALL in VECTOR assert pc_sel=1, pc_redirect=VECTOR_ADDR for exactly one cycle, then enter HANDLER.
REQ-027 SHALL in HANDLER ignore overflow, trap, store_int and irq_ext (no queueing, epc/cause unchanged) and wait for eret.
REQ-028 SHALL on eret in HANDLER enter RETURN; there assert pc_sel=1, pc_redirect=epc, flush=1 for one cycle, set int_en=1, clear cause to 0, then return to IDLE.
REQ-029 SHALL ignore eret in any state other than HANDLER; eret with simultaneous event in HANDLER is treated as eret only.
REQ-030 SHALL hold pc_sel=0, flush=0 and pc_redirect=0 whenever not otherwise specified.
REQ-031 SHALL re-sample irq_ext in IDLE the cycle after RETURN; a still-asserted level is accepted there (minimum one IDLE cycle between handlers).
REQ-032 SHALL keep epc stable from capture until the next accepted event.

Reset
REQ-033 SHALL, while reset=1, force state=IDLE, flush counter=0, epc=0, cause=0, int_en=0, flush=0, in_handler=0, pc_sel=1, pc_redirect=RESET_PC.
REQ-034 SHALL let reset override every state including mid-flush and HANDLER; first cycle after reset deasserts is IDLE with pc_sel=0.
REQ-035 SHALL keep int_en=0 after reset until the first RETURN.

Verification
REQ-036 SHALL check trap pulse in IDLE with pc_8_in=32'h0001_0020 -> epc=32'h0001_001C, cause=2, flush high 2 cycles, then pc_sel=1/pc_redirect=32'h0000_0080 one cycle.
REQ-037 SHALL check overflow and trap same cycle, pc_8_in=32'h0001_0010 -> cause=1, epc=32'h0001_0008.
REQ-038 SHALL check irq_ext=1 after reset with int_en=0 -> no acceptance; after a handled trap and eret -> pc_redirect=epc, int_en=1, irq_ext accepted one IDLE cycle later with cause=4.
REQ-039 SHALL check trap during HANDLER and eret in IDLE -> no state, epc or cause change.
REQ-040 SHALL check reset asserted during FLUSH -> next cycle pc_redirect=32'h0001_0000, pc_sel=1, flush=0, epc=0.
REQ-041 SHALL check pc_8_in=32'h0000_0004 with overflow -> epc=32'hFFFF_FFFC (wrap).

Source files
------------

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: picks one pending event in IDLE, flushes the
// pipeline, vectors to the handler, and returns to epc on eret.
module exception_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0001_0000,
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0080,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        overflow,
    input  logic        trap,
    input  logic        memwrite,
    input  logic        oint_ex,
    input  logic        irq_ext,
    input  logic        eret,
    input  logic [31:0] pc_8_in,
    output logic        flush,
    output logic        pc_sel,
    output logic [31:0] pc_redirect,
    output logic [31:0] epc,
    output logic [2:0]  cause,
    output logic        int_en,
    output logic        in_handler
);

    typedef enum logic [2:0] {IDLE, FLUSH, VECTOR, HANDLER, RETURN} state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    state_t      state, state_next;
    logic [1:0]  cnt;
    logic        store_int, accept;
    logic [2:0]  win_code;
    logic [31:0] win_epc;

    assign store_int = memwrite & oint_ex;

    // Fixed priority; faulting events re-execute (pc-8), others resume after (pc-4).
    always_comb begin
        win_code = 3'd0;
        win_epc  = pc_8_in - 32'd8;
        if (overflow) begin
            win_code = 3'd1;
        end else if (trap) begin
            win_code = 3'd2;
            win_epc  = pc_8_in - 32'd4;
        end else if (store_int) begin
            win_code = 3'd3;
            win_epc  = pc_8_in - 32'd4;
        end else if (irq_ext && int_en) begin
            win_code = 3'd4;
        end
        accept = (win_code != 3'd0);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = FLUSH;
            FLUSH:   if (cnt == 2'd1) state_next = VECTOR;
            VECTOR:  state_next = HANDLER;
            HANDLER: if (eret) state_next = RETURN;
            RETURN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            epc    <= 32'd0;
            cause  <= 3'd0;
            int_en <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (accept) begin
                    cause  <= win_code;
                    epc    <= win_epc;
                    int_en <= 1'b0;
                    cnt    <= FLUSH_INIT;
                end
                FLUSH:  cnt <= cnt - 2'd1;
                RETURN: begin
                    int_en <= 1'b1;
                    cause  <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    // Reset drives the fetch unit to RESET_PC combinationally, independent of state.
    always_comb begin
        flush       = 1'b0;
        pc_sel      = 1'b0;
        pc_redirect = 32'd0;
        in_handler  = 1'b0;
        if (reset) begin
            pc_sel      = 1'b1;
            pc_redirect = RESET_PC;
        end else begin
            in_handler = (state != IDLE);
            case (state)
                FLUSH:  flush = 1'b1;
                VECTOR: begin
                    pc_sel      = 1'b1;
                    pc_redirect = VECTOR_ADDR;
                end
                RETURN: begin
                    pc_sel      = 1'b1;
                    pc_redirect = epc;
                    flush       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed table of cycle-by-cycle vectors, then random traffic checked against
// a timeline model (cycles since acceptance) of the exception sequence.
module tb_exception_ctrl;

    localparam logic [31:0] RP = 32'h0001_0000;
    localparam logic [31:0] VA = 32'h0000_0080;
    localparam int          F  = 2;
    localparam logic        H  = 1'b1, L = 1'b0;

    logic        clk = 1'b0;
    logic        reset, overflow, trap, memwrite, oint_ex, irq_ext, eret;
    logic [31:0] pc_8_in;
    logic        flush, pc_sel, int_en, in_handler;
    logic [31:0] pc_redirect, epc;
    logic [2:0]  cause;

    int n_chk = 0, n_fail = 0;

    exception_ctrl #(.RESET_PC(RP), .VECTOR_ADDR(VA), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .reset(reset), .overflow(overflow), .trap(trap),
        .memwrite(memwrite), .oint_ex(oint_ex), .irq_ext(irq_ext), .eret(eret),
        .pc_8_in(pc_8_in), .flush(flush), .pc_sel(pc_sel), .pc_redirect(pc_redirect),
        .epc(epc), .cause(cause), .int_en(int_en), .in_handler(in_handler)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ov, tr, mw, oi, irq, er;
        logic [31:0] pc8;
        logic        fl, ps;
        logic [31:0] red, ep;
        logic [2:0]  cs;
        logic        ie, ih;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rst, ov, tr, mw, oi, irq, er, input logic [31:0] pc8,
                     input logic fl, ps, input logic [31:0] red, ep,
                     input logic [2:0] cs, input logic ie, ih);
        vec_t t;
        t.rst = rst; t.ov = ov; t.tr = tr; t.mw = mw; t.oi = oi; t.irq = irq; t.er = er;
        t.pc8 = pc8; t.fl = fl; t.ps = ps; t.red = red; t.ep = ep; t.cs = cs;
        t.ie = ie; t.ih = ih;
        vecs.push_back(t);
    endtask

    task automatic chk(input string tag, input int idx, input logic [31:0] act, exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", tag, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic fl, ps, input logic [31:0] red, ep,
                             input logic [2:0] cs, input logic ie, ih);
        chk("flush", idx, 32'(flush), 32'(fl));
        chk("pc_sel", idx, 32'(pc_sel), 32'(ps));
        chk("pc_redirect", idx, pc_redirect, red);
        chk("epc", idx, epc, ep);
        chk("cause", idx, 32'(cause), 32'(cs));
        chk("int_en", idx, 32'(int_en), 32'(ie));
        chk("in_handler", idx, 32'(in_handler), 32'(ih));
    endtask

    // Reference model: idle flag plus age since acceptance determines the phase.
    logic        m_idle, m_ret, m_ie;
    int          m_age;
    logic [31:0] m_epc;
    logic [2:0]  m_cause;

    task automatic model_step();
        if (reset) begin
            m_idle = 1'b1; m_ret = 1'b0; m_ie = 1'b0; m_age = 0;
            m_epc = 32'd0; m_cause = 3'd0;
        end else if (m_idle) begin
            logic [2:0] c;
            c = overflow ? 3'd1 : trap ? 3'd2 : (memwrite && oint_ex) ? 3'd3
              : (irq_ext && m_ie) ? 3'd4 : 3'd0;
            if (c != 3'd0) begin
                m_cause = c;
                m_epc   = (c == 3'd2 || c == 3'd3) ? pc_8_in - 32'd4 : pc_8_in - 32'd8;
                m_ie    = 1'b0;
                m_idle  = 1'b0;
                m_age   = 1;
            end
        end else if (m_ret) begin
            m_idle = 1'b1; m_ret = 1'b0; m_ie = 1'b1; m_cause = 3'd0;
        end else if (m_age > F + 1) begin
            if (eret) m_ret = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    task automatic model_check(input int idx);
        logic fl, ps;
        logic [31:0] red;
        fl = 1'b0; ps = 1'b0; red = 32'd0;
        if (reset) begin
            ps = 1'b1; red = RP;
        end else if (!m_idle) begin
            if (m_ret) begin
                ps = 1'b1; red = m_epc; fl = 1'b1;
            end else if (m_age <= F) begin
                fl = 1'b1;
            end else if (m_age == F + 1) begin
                ps = 1'b1; red = VA;
            end
        end
        check_all(idx, fl, ps, red, m_epc, m_cause, m_ie, !reset && !m_idle);
    endtask

    initial begin
        reset = 1'b1; overflow = 1'b0; trap = 1'b0; memwrite = 1'b0; oint_ex = 1'b0;
        irq_ext = 1'b0; eret = 1'b0; pc_8_in = 32'd0;
        m_idle = 1'b1; m_ret = 1'b0; m_ie = 1'b0; m_age = 0; m_epc = 32'd0; m_cause = 3'd0;

        //  rst ov tr mw oi irq er  pc8            fl ps red            epc            cs ie ih
        v(H, L, L, L, L, L, L, 32'h0,          L, H, RP,            32'h0,         3'd0, L, L);
        v(L, L, L, L, L, H, L, 32'h0,          L, L, 32'h0,         32'h0,         3'd0, L, L);
        v(L, L, H, L, L, L, L, 32'h0001_0020,  L, L, 32'h0,         32'h0,         3'd0, L, L);
        v(L, L, L, L, L, L, L, 32'h0,          H, L, 32'h0,         32'h0001_001C, 3'd2, L, H);
        v(L, L, H, L, L, L, L, 32'h0,          H, L, 32'h0,         32'h0001_001C, 3'd2, L, H);
        v(L, L, L, L, L, L, L, 32'h0,          L, H, VA,            32'h0001_001C, 3'd2, L, H);
        v(L, H, H, L, L, L, L, 32'h500,        L, L, 32'h0,         32'h0001_001C, 3'd2, L, H);
        v(L, L, L, L, L, H, H, 32'h0,          L, L, 32'h0,         32'h0001_001C, 3'd2, L, H);
        v(L, L, L, L, L, H, L, 32'h0,          H, H, 32'h0001_001C, 32'h0001_001C, 3'd2, L, H);
        v(L, L, L, L, L, H, L, 32'h2000,       L, L, 32'h0,         32'h0001_001C, 3'd0, H, L);
        v(L, L, L, L, L, L, L, 32'h0,          H, L, 32'h0,         32'h1FF8,      3'd4, L, H);
        v(L, L, L, L, L, L, L, 32'h0,          H, L, 32'h0,         32'h1FF8,      3'd4, L, H);
        v(L, L, L, L, L, L, L, 32'h0,          L, H, VA,            32'h1FF8,      3'd4, L, H);
        v(L, L, L, L, L, L, H, 32'h0,          L, L, 32'h0,         32'h1FF8,      3'd4, L, H);
        v(L, L, L, L, L, L, L, 32'h0,          H, H, 32'h1FF8,      32'h1FF8,      3'd4, L, H);
        v(L, L, L, L, L, L, H, 32'h0,          L, L, 32'h0,         32'h1FF8,      3'd0, H, L);
        v(L, H, H, L, L, L, L, 32'h0001_0010,  L, L, 32'h0,         32'h1FF8,      3'd0, H, L);
        v(H, L, L, L, L, L, L, 32'h0,          L, H, RP,            32'h0001_0008, 3'd1, L, L);
        v(H, L, L, L, L, L, L, 32'h0,          L, H, RP,            32'h0,         3'd0, L, L);
        v(L, H, L, L, L, L, L, 32'h4,          L, L, 32'h0,         32'h0,         3'd0, L, L);
        v(L, L, L, L, L, L, L, 32'h0,          H, L, 32'h0,         32'hFFFF_FFFC, 3'd1, L, H);
        v(L, L, L, L, L, L, L, 32'h0,          H, L, 32'h0,         32'hFFFF_FFFC, 3'd1, L, H);
        v(L, L, L, L, L, L, L, 32'h0,          L, H, VA,            32'hFFFF_FFFC, 3'd1, L, H);
        v(L, L, L, L, L, L, H, 32'h0,          L, L, 32'h0,         32'hFFFF_FFFC, 3'd1, L, H);
        v(L, L, L, L, L, L, L, 32'h0,          H, H, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 3'd1, L, H);
        v(L, L, L, H, L, L, L, 32'h0,          L, L, 32'h0,         32'hFFFF_FFFC, 3'd0, H, L);
        v(L, L, L, H, H, H, L, 32'h3008,       L, L, 32'h0,         32'hFFFF_FFFC, 3'd0, H, L);
        v(L, L, L, L, L, L, L, 32'h0,          H, L, 32'h0,         32'h3004,      3'd3, L, H);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset = vecs[i].rst; overflow = vecs[i].ov; trap = vecs[i].tr;
            memwrite = vecs[i].mw; oint_ex = vecs[i].oi; irq_ext = vecs[i].irq;
            eret = vecs[i].er; pc_8_in = vecs[i].pc8;
            @(negedge clk);
            check_all(i, vecs[i].fl, vecs[i].ps, vecs[i].red, vecs[i].ep,
                      vecs[i].cs, vecs[i].ie, vecs[i].ih);
        end

        @(posedge clk); #1;
        reset = 1'b1; overflow = 1'b0; trap = 1'b0; memwrite = 1'b0; oint_ex = 1'b0;
        irq_ext = 1'b0; eret = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            reset    = ($urandom_range(99) < 2);
            overflow = ($urandom_range(99) < 8);
            trap     = ($urandom_range(99) < 8);
            memwrite = ($urandom_range(99) < 25);
            oint_ex  = ($urandom_range(99) < 30);
            irq_ext  = ($urandom_range(99) < 40);
            eret     = ($urandom_range(99) < 30);
            pc_8_in  = $urandom;
            @(negedge clk);
            model_check(1000 + c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
